// File: rtl/quant_driver.sv
// Issuing-side sequencer for the quant requantizer: feeds operands from a
// per-channel parameter table, collects int8 results and packs them four per word.
module quant_driver #(
    parameter int N_CH    = 8,
    parameter int TIMEOUT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [$clog2(N_CH)-1:0] cfg_addr,
    input  logic [31:0]             cfg_bias,
    input  logic [31:0]             cfg_mult,
    input  logic [31:0]             cfg_shift,
    input  logic                    ch_clear,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_acc,
    output logic                    q_start,
    output logic [31:0]             q_acc,
    output logic [31:0]             q_bias,
    output logic [31:0]             q_mult,
    output logic [31:0]             q_shift,
    input  logic                    q_ret_valid,
    input  logic [31:0]             q_ret,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_data,
    output logic [2:0]              out_lanes,
    output logic                    err
);

    localparam int CW = $clog2(N_CH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {GUARD, IDLE, ISSUE, WAIT_RISE, WAIT_FALL} state_t;

    state_t       state;
    logic [2:0]   guard_cnt;
    logic [TW-1:0] tcnt;
    logic [CW-1:0] ch;
    logic [2:0]   lane_cnt;
    logic         flush_pend;

    logic [31:0] bias_tab  [N_CH];
    logic [31:0] mult_tab  [N_CH];
    logic [31:0] shift_tab [N_CH];

    logic          idle_now, flush_fire, accept, out_fire;
    logic          capture, timeout, lane_wr;
    logic [7:0]    lane_byte;
    logic [CW-1:0] ch_sel;
    logic [31:0]   next_data;
    logic [2:0]    next_cnt;
    logic          next_valid;
    logic          ret_unused;

    assign ret_unused = ^q_ret[31:8];

    // Table is deliberately not reset; a same-cycle read sees the old entry.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            bias_tab[cfg_addr]  <= cfg_bias;
            mult_tab[cfg_addr]  <= cfg_mult;
            shift_tab[cfg_addr] <= cfg_shift;
        end
    end

    // WAIT_FALL with ret_valid low behaves as IDLE so an element takes 7 cycles.
    always_comb begin
        idle_now   = (state == IDLE) || (state == WAIT_FALL && !q_ret_valid);
        flush_fire = idle_now && (flush || flush_pend) && (lane_cnt != 3'd0) && !out_valid;
        in_ready   = idle_now && !(out_valid && lane_cnt == 3'd4) && !flush_fire;
        accept     = in_valid && in_ready;
        out_fire   = out_valid && out_ready;
        ch_sel     = ch_clear ? '0 : ch;
        q_start    = (state == ISSUE);
        out_lanes  = lane_cnt;
        capture    = (state == WAIT_RISE) && q_ret_valid;
        timeout    = (state == WAIT_RISE) && !q_ret_valid && (tcnt == TW'(TIMEOUT - 2));
        lane_wr    = capture || timeout;
        lane_byte  = capture ? q_ret[7:0] : 8'h00;
    end

    always_comb begin
        next_data  = out_fire ? 32'd0 : out_data;
        next_cnt   = out_fire ? 3'd0 : lane_cnt;
        next_valid = out_fire ? 1'b0 : out_valid;
        if (lane_wr) begin
            next_data[{next_cnt[1:0], 3'b000} +: 8] = lane_byte;
            next_cnt = next_cnt + 3'd1;
            if (next_cnt == 3'd4)
                next_valid = 1'b1;
        end else if (flush_fire) begin
            next_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= GUARD;
            guard_cnt  <= '0;
            tcnt       <= '0;
            ch         <= '0;
            lane_cnt   <= '0;
            flush_pend <= 1'b0;
            q_acc      <= '0;
            q_bias     <= '0;
            q_mult     <= '0;
            q_shift    <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            err        <= 1'b0;
        end else begin
            out_data  <= next_data;
            lane_cnt  <= next_cnt;
            out_valid <= next_valid;

            if (ch_clear)
                ch <= accept ? CW'(1) : '0;
            else if (accept)
                ch <= ch + CW'(1);

            if (idle_now)
                flush_pend <= 1'b0;
            else if (flush)
                flush_pend <= 1'b1;

            case (state)
                // quant has no reset and may still be finishing an old sequence.
                GUARD: begin
                    if (guard_cnt == 3'd5)
                        state <= IDLE;
                    else
                        guard_cnt <= guard_cnt + 3'd1;
                end
                IDLE, WAIT_FALL: begin
                    if (accept) begin
                        q_acc   <= in_acc;
                        q_bias  <= bias_tab[ch_sel];
                        q_mult  <= mult_tab[ch_sel];
                        q_shift <= shift_tab[ch_sel];
                        state   <= ISSUE;
                    end else if (idle_now) begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    tcnt  <= '0;
                    state <= WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (capture) begin
                        state <= WAIT_FALL;
                    end else if (timeout) begin
                        err   <= 1'b1;
                        state <= WAIT_FALL;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: state <= GUARD;
            endcase
        end
    end

endmodule

// File: tb/tb_quant_driver.sv
// Scoreboard bench for quant_driver with a behavioural quant stub.
module tb_quant_driver;

    localparam int N_CH    = 8;
    localparam int TIMEOUT = 8;
    localparam int M_NOM   = 1;
    localparam int M_NEVER = 2;
    localparam int M_HOLD  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_bias, cfg_mult, cfg_shift;
    logic        ch_clear, flush, in_valid, in_ready;
    logic [31:0] in_acc;
    logic        q_start;
    logic [31:0] q_acc, q_bias, q_mult, q_shift;
    logic        q_ret_valid;
    logic [31:0] q_ret;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_lanes;
    logic        err;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int mode = M_NOM;
    int t = 0;
    logic [31:0] s_ret = 32'd0;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  lanes;
    } exp_t;
    exp_t exp_q[$];
    int   start_q[$];
    int   last_start = 0;
    int   err_cyc = -1;
    int   ov_rise = 0;
    logic ov_prev = 1'b0;

    quant_driver #(.N_CH(N_CH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_bias(cfg_bias), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
        .ch_clear(ch_clear), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
        .q_start(q_start), .q_acc(q_acc), .q_bias(q_bias), .q_mult(q_mult), .q_shift(q_shift),
        .q_ret_valid(q_ret_valid), .q_ret(q_ret),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_lanes(out_lanes), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Q31 multiply of (acc + bias) with round-half-up, then arithmetic shift.
    function automatic logic [31:0] quant_model(input logic [31:0] a, input logic [31:0] b,
                                                input logic [31:0] m, input logic [31:0] s);
        longint sum, p;
        sum = longint'($signed(a)) + longint'($signed(b));
        p   = sum * longint'($signed(m)) + 64'sd1073741824;
        p   = p >>> 31;
        p   = p >>> s[5:0];
        return p[31:0];
    endfunction

    // quant stub: ret_valid follows the start pulse by 4 cycles
    always @(posedge clk) begin
        if (q_start) begin
            t     <= 1;
            s_ret <= quant_model(q_acc, q_bias, q_mult, q_shift);
        end else if (t > 0 && t < 1000) begin
            t <= t + 1;
        end
    end
    assign q_ret_valid = (mode == M_NOM  && t >= 4 && t <= 5) ||
                         (mode == M_HOLD && t >= 4 && t <= 8);
    assign q_ret = s_ret;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard on each output handshake.
    always @(negedge clk) begin
        if (q_start) begin
            start_q.push_back(cyc);
            last_start = cyc;
        end
        if (err && err_cyc < 0)
            err_cyc = cyc;
        if (out_valid && !ov_prev)
            ov_rise = cyc;
        ov_prev = out_valid;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_word: got 0x%08h lanes %0d, none expected", out_data, out_lanes);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("word_data", out_data, e.data);
                checkOutput("word_lanes", {29'd0, out_lanes}, {29'd0, e.lanes});
            end
        end
    end

    task automatic pushExp(input logic [31:0] d, input logic [2:0] l);
        exp_t e;
        e.data  = d;
        e.lanes = l;
        exp_q.push_back(e);
    endtask

    task automatic cfgWrite(input int a, input logic [31:0] b, input logic [31:0] m, input logic [31:0] s);
        cfg_we = 1'b1; cfg_addr = 3'(a); cfg_bias = b; cfg_mult = m; cfg_shift = s;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] acc, input logic clr);
        int n = 0;
        in_valid = 1'b1; in_acc = acc; ch_clear = clr;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout: in_ready 0, required 1 within 300 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0; ch_clear = 1'b0;
    endtask

    task automatic doFlush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int n;
        int starts;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_bias = '0; cfg_mult = '0; cfg_shift = '0;
        ch_clear = 1'b0; flush = 1'b0; in_valid = 1'b0; in_acc = '0; out_ready = 1'b1;

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_q_start", {31'd0, q_start}, 32'd0);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        checkOutput("rst_out_lanes", {29'd0, out_lanes}, 32'd0);
        checkOutput("rst_q_acc", q_acc, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // full word: results 5, 10, -15, 20
        for (int i = 0; i < 4; i++) cfgWrite(i, 32'd0, 32'h4000_0000, 32'd0);
        start_q.delete();
        pushExp(32'h14F1_0A05, 3'd4);
        applyStimulus(32'd10, 1'b1);
        applyStimulus(32'd20, 1'b0);
        applyStimulus(-32'sd30, 1'b0);
        applyStimulus(32'd40, 1'b0);
        waitDrain(100);
        checkOutput("start_count", start_q.size(), 32'd4);
        if (start_q.size() == 4) begin
            for (int i = 1; i < 4; i++)
                checkOutput("start_spacing", start_q[i] - start_q[i-1], 32'd7);
            checkOutput("out_valid_latency", ov_rise - start_q[3], 32'd5);
        end

        // channel wrap: ch k has bias 20k, acc 2 gives 1 + 10k
        for (int i = 0; i < N_CH; i++) cfgWrite(i, 32'(20 * i), 32'h4000_0000, 32'd0);
        pushExp(32'h1F15_0B01, 3'd4);
        pushExp(32'h473D_3329, 3'd4);
        pushExp(32'h0000_0001, 3'd1);
        applyStimulus(32'd2, 1'b1);
        for (int i = 1; i < 9; i++) applyStimulus(32'd2, 1'b0);
        doFlush();
        waitDrain(200);

        // ch_clear on element 3 with the word held by back-pressure
        out_ready = 1'b0;
        pushExp(32'h0B01_150B, 3'd4);
        applyStimulus(32'd2, 1'b0);
        applyStimulus(32'd2, 1'b0);
        applyStimulus(32'd2, 1'b1);
        applyStimulus(32'd2, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("bp_out_data", out_data, 32'h0B01_150B);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("bp_release", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        waitDrain(10);

        // flush of a partial word: ch0 -> 5, ch1 -> 20
        pushExp(32'h0000_1405, 3'd2);
        applyStimulus(32'd10, 1'b1);
        applyStimulus(32'd20, 1'b0);
        doFlush();
        waitDrain(100);

        // timeout: no ret_valid ever
        mode = M_NEVER;
        err_cyc = -1;
        applyStimulus(32'd2, 1'b1);
        repeat (14) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("timeout_err", {31'd0, err}, 32'd1);
        checkOutput("timeout_cycles", err_cyc - last_start, 32'(TIMEOUT));
        @(posedge clk); #1;
        pushExp(32'h0000_0000, 3'd1);
        doFlush();
        waitDrain(50);

        // ret_valid held 5 cycles: exactly one capture
        mode = M_HOLD;
        pushExp(32'h0000_0001, 3'd1);
        applyStimulus(32'd2, 1'b1);
        doFlush();
        waitDrain(100);
        checkOutput("err_sticky", {31'd0, err}, 32'd1);

        // reset in WAIT_RISE with a partial word pending
        mode = M_NOM;
        applyStimulus(32'd2, 1'b1);
        applyStimulus(32'd2, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("mid_rst_q_start", {31'd0, q_start}, 32'd0);
        checkOutput("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_err", {31'd0, err}, 32'd0);
        checkOutput("mid_rst_out_data", out_data, 32'd0);
        checkOutput("mid_rst_out_lanes", {29'd0, out_lanes}, 32'd0);
        checkOutput("mid_rst_q_bias", q_bias, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b1; in_acc = 32'd2; ch_clear = 1'b1;
        starts = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (q_start || in_ready) starts++;
        end
        checkOutput("guard_quiet", starts, 32'd0);
        pushExp(32'h0000_0001, 3'd1);
        applyStimulus(32'd2, 1'b1);
        doFlush();
        waitDrain(100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] time limit");
    end

endmodule

// File: doc/quant_driver.md
# quant_driver

Sequencer on the issuing side of the `quant` requantizer handshake. It accepts a stream of int32 accumulator values and supplies each one to `quant`, together with the per-channel bias, multiplier and shift from a small parameter table. It pulses `start`, waits for the `ret_valid` window and captures the int8 result. It packs four results into one 32-bit word for the CFU response path.

## Interface
Parameters:
- `N_CH`, 8: number of output channels in the parameter table. Must be a power of two, ≥ 2.
- `TIMEOUT`, 8: cycles allowed from `q_start` to the rising edge of `q_ret_valid`.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `cfg_we`, in, 1: parameter table write strobe.
- `cfg_addr`, in, $clog2(N_CH): table index.
- `cfg_bias` / `cfg_mult` / `cfg_shift`, in, 32 each: signed entry values.
- `ch_clear`, in, 1: synchronous reset of the channel counter.
- `flush`, in, 1: emit a partial word.
- `in_valid`, in, 1 / `in_ready`, out, 1: input handshake.
- `in_acc`, in, 32: signed accumulator.
- `q_start`, out, 1: start pulse to `quant`.
- `q_acc` / `q_bias` / `q_mult` / `q_shift`, out, 32 each: operands to `quant`.
- `q_ret_valid`, in, 1 / `q_ret`, in, 32: result from `quant`.
- `out_valid`, out, 1 / `out_ready`, in, 1: output handshake.
- `out_data`, out, 32: packed result word.
- `out_lanes`, out, 3: count of valid bytes in `out_data`, 1..4.
- `err`, out, 1: sticky timeout flag.

## Operation
- **Parameter table:** `N_CH` × {bias, mult, shift}. Not reset. A write lands at the clock edge. Reads are combinational and happen at input accept. If a write and a read hit the same address in the same cycle, the read returns the old value.
- **Channel counter:**
  - `ch` increments on each accepted element and wraps from `N_CH-1` to 0.
  - `ch_clear` has priority. If an element is accepted in the same cycle, that element uses channel 0 and `ch` becomes 1; otherwise `ch` becomes 0.
- **FSM states:**
  - `GUARD`: entered on reset. Holds for 6 cycles because `quant` has no reset and may still be mid-sequence. Then goes to `IDLE`.
  - `IDLE`: `in_ready` = !(`out_valid` && lane_cnt == 4). On accept, registers `in_acc` into `q_acc`, loads the table entry for `ch` into `q_bias` / `q_mult` / `q_shift`, and goes to `ISSUE`.
  - `ISSUE`: `q_start` = 1 for exactly one cycle. Go to `WAIT_RISE`.
  - `WAIT_RISE`: on `q_ret_valid` = 1, write `q_ret[7:0]` into byte lane lane_cnt (lane 0 = bits 7:0), increment lane_cnt, go to `WAIT_FALL`. If `TIMEOUT` cycles pass without the rise, set `err`, write 0x00 into the lane, and go to `WAIT_FALL`.
  - `WAIT_FALL`: return to `IDLE` on the first cycle `q_ret_valid` = 0. This guarantees `quant` is idle and a result is never counted twice.
- **Operand hold:** `q_*` stay stable from accept until the FSM leaves `WAIT_FALL`. This is required because `quant` samples its overflow compare combinationally.
- **Output word:**
  - `out_valid` asserts when lane_cnt reaches 4.
  - `out_valid` also asserts on `flush` in `IDLE` with lane_cnt > 0. Unused lanes are zero.
  - `out_lanes` = lane_cnt.
  - On `out_valid && out_ready`: clear lane_cnt and the data, deassert `out_valid`.
  - `flush` with lane_cnt = 0 is ignored. `flush` outside `IDLE` is held pending until `IDLE`.
- **Error:** `err` is cleared only by `rst_n`.

## Timing
- **Reset values:**
  - `in_ready`=0, `q_start`=0, `out_valid`=0, `err`=0.
  - `out_data`=0, `out_lanes`=0.
  - `q_*`=0, `ch`=0, lane_cnt=0.
  - State = `GUARD`.
- **Reset during a transaction:** `rst_n` asserted mid-transaction discards the partial word and any in-flight element.
- **Per-element sequence with nominal `quant`**, accept at cycle T:
  - `q_start` high at T+1.
  - `q_ret_valid` high at T+5 and T+6.
  - Capture at the T+5 edge.
  - `IDLE` / `in_ready` at T+7.
  - Result: 7 cycles per element.
- **Output timing:** `out_valid` rises the cycle after the fourth capture.
- **Back-pressure:** while a full word is stalled on `out_ready`=0, `in_ready` stays 0.
- **Start spacing:** `q_start` is never asserted while `q_ret_valid` = 1, or within one cycle after it falls.

## Test plan
- **Full word:**
  - Stimulus: load ch0..3 with bias 0, mult 0x40000000, shift 0; send acc 10, 20, -30, 40.
  - Response: one `q_start` per element spaced 7 cycles apart, and `out_data` equal to the four packed `quant` results. `out_lanes`=4; `out_valid` rises 1 cycle after the fourth capture.
- **Channel wrap and clear:**
  - Stimulus: `N_CH`=8; send 9 elements.
  - Response: the ninth uses the ch0 params.
  - Stimulus: assert `ch_clear` together with element 3.
  - Response: element 3 uses ch0 and element 4 uses ch1.
- **Back-pressure:** stimulus: hold `out_ready`=0 after a full word. Response: `in_ready` stays 0 and `out_data` stays stable; on release, handshake completes in 1 cycle.
- **Flush:** stimulus: send 2 elements, then `flush`. Response: `out_lanes`=2, upper 16 bits zero.
- **Timeout:** stimulus: a `quant` stub that never raises `ret_valid`. Response: `err`=1 exactly `TIMEOUT` cycles after `q_start` and the lane holds 0x00. Stimulus: a stub holding `ret_valid` for 5 cycles. Response: exactly one capture.
- **Reset:** stimulus: drop `rst_n` in `WAIT_RISE`. Response: all outputs go to reset values immediately, and there is no `q_start` for 6 cycles after release.
